dac_wr_arbiter: RTL and testbench

- Shares one 24-bit SPI DAC master (serving a dual-channel DAC) between three requesters: the Wishbone threshold write and the ch1 and ch2 measure controllers.
- Builds each frame as {command byte, 16-bit code} and issues it with a one-cycle write strobe.
- Waits for the SPI master's ready handshake to complete, then acknowledges the requester.
- Sits between the measure-unit register logic / channel controllers and the SPI master, in the Wishbone clock domain.

---
 rtl/dac_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_dac_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dac_wr_arbiter
//  Purpose  : Shares one 24-bit SPI DAC master between the Wishbone threshold
//             write and the ch1/ch2 measure controllers. Each frame is
//             {command byte, code}. A frame is sent as a one-cycle write strobe.
//             The arbiter then waits for the SPI master's ready handshake and
//             acknowledges the requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i    clock (Wishbone domain)
//    wb_rst_i    synchronous active-high reset
//    wb_wre_i    1-cycle pulse: write wb_code_i to both DAC channels
//    wb_code_i   Wishbone threshold code
//    ch1_req_i   ch1 level request, held until ch1_ack_o
//    ch1_code_i  ch1 code
//    ch2_req_i   ch2 level request, held until ch2_ack_o
//    ch2_code_i  ch2 code
//    ch1_ack_o   1-cycle pulse: ch1 frame completed
//    ch2_ack_o   1-cycle pulse: ch2 frame completed
//    wb_done_o   1-cycle pulse: both Wishbone frames completed
//    wb_pend_o   Wishbone write latched and not yet completed
//    spi_data_o  frame to SPI master
//    spi_wre_o   1-cycle frame write strobe
//    spi_rdy_i   SPI master ready (high = idle)
//    busy_o      FSM not in IDLE
//    err_o       sticky: SPI master never went busy within BUSY_TIMEOUT
// ============================================================================
module dac_wr_arbiter #(
  parameter int              DATA_WIDTH   = 16,
  parameter logic [7:0]      CMD_CH1      = 8'h18,
  parameter logic [7:0]      CMD_CH2      = 8'h19,
  parameter int              BUSY_TIMEOUT = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_wre_i,
  input  logic [DATA_WIDTH-1:0]   wb_code_i,
  input  logic                    ch1_req_i,
  input  logic [DATA_WIDTH-1:0]   ch1_code_i,
  input  logic                    ch2_req_i,
  input  logic [DATA_WIDTH-1:0]   ch2_code_i,
  output logic                    ch1_ack_o,
  output logic                    ch2_ack_o,
  output logic                    wb_done_o,
  output logic                    wb_pend_o,
  output logic [DATA_WIDTH+7:0]   spi_data_o,
  output logic                    spi_wre_o,
  input  logic                    spi_rdy_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int                 c_CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  // The counter is loaded with 1 in ISSUE. So the last WAIT_BUSY cycle before
  // the timeout is the one where it holds BUSY_TIMEOUT-1. This makes err_o
  // rise exactly BUSY_TIMEOUT cycles after the write strobe.
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_ONE  = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SRC_CH1 = 2'd0,
    SRC_CH2 = 2'd1,
    SRC_WB  = 2'd2
  } src_t;

  state_t                  r_state;
  src_t                    r_src;
  logic                    r_wb_second;   // second (CMD_CH2) frame of a Wishbone pair
  logic                    r_rr_ptr;      // 0: ch1 preferred, 1: ch2 preferred
  logic [c_CNT_W-1:0]      r_tmo_cnt;
  logic                    r_wb_pend;
  logic [DATA_WIDTH-1:0]   r_wb_code;
  logic                    r_wb_requeue;  // write arrived after its pair started
  logic [DATA_WIDTH-1:0]   r_wb_next;
  logic [DATA_WIDTH+7:0]   r_spi_data;
  logic                    r_spi_wre;
  logic                    r_ch1_ack;
  logic                    r_ch2_ack;
  logic                    r_wb_done;
  logic                    r_err;

  logic                    w_gnt_wb;
  logic                    w_gnt_ch1;
  logic                    w_gnt_ch2;
  logic                    w_wb_active;
  logic                    w_complete;

  // Arbitration is only evaluated in IDLE with the SPI master idle.
  always_comb begin
    w_gnt_wb  = 1'b0;
    w_gnt_ch1 = 1'b0;
    w_gnt_ch2 = 1'b0;
    if (r_state == S_IDLE && spi_rdy_i) begin
      if (r_wb_pend) begin
        w_gnt_wb = 1'b1;
      end else if (ch1_req_i && (!ch2_req_i || !r_rr_ptr)) begin
        w_gnt_ch1 = 1'b1;
      end else if (ch2_req_i) begin
        w_gnt_ch2 = 1'b1;
      end
    end
  end

  // Once a Wishbone pair has been granted, its code is in use. A new write
  // then has to queue instead of overwriting the code.
  assign w_wb_active = w_gnt_wb || (r_state != S_IDLE && r_src == SRC_WB);

  // Frame complete: the ready handshake finished, or the timeout expired.
  assign w_complete = (r_state == S_WAIT_DONE && spi_rdy_i) ||
                      (r_state == S_WAIT_BUSY && spi_rdy_i && r_tmo_cnt >= c_TMO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_src        <= SRC_CH1;
      r_wb_second  <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_tmo_cnt    <= '0;
      r_wb_pend    <= 1'b0;
      r_wb_code    <= '0;
      r_wb_requeue <= 1'b0;
      r_wb_next    <= '0;
      r_spi_data   <= '0;
      r_spi_wre    <= 1'b0;
      r_ch1_ack    <= 1'b0;
      r_ch2_ack    <= 1'b0;
      r_wb_done    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_spi_wre <= 1'b0;
      r_ch1_ack <= 1'b0;
      r_ch2_ack <= 1'b0;
      r_wb_done <= 1'b0;

      // Wishbone write latch
      if (wb_wre_i) begin
        if (w_wb_active) begin
          r_wb_requeue <= 1'b1;
          r_wb_next    <= wb_code_i;
        end else begin
          r_wb_pend    <= 1'b1;
          r_wb_code    <= wb_code_i;
        end
      end

      // Completion pulses become visible during DONE. That is one cycle after
      // ready is seen high again.
      if (w_complete) begin
        r_ch1_ack <= (r_src == SRC_CH1);
        r_ch2_ack <= (r_src == SRC_CH2);
        r_wb_done <= (r_src == SRC_WB) && r_wb_second;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_wb) begin
            r_spi_data  <= {CMD_CH1, r_wb_code};
            r_src       <= SRC_WB;
            r_wb_second <= 1'b0;
            r_spi_wre   <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (w_gnt_ch1) begin
            r_spi_data  <= {CMD_CH1, ch1_code_i};
            r_src       <= SRC_CH1;
            r_rr_ptr    <= 1'b1;
            r_spi_wre   <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (w_gnt_ch2) begin
            r_spi_data  <= {CMD_CH2, ch2_code_i};
            r_src       <= SRC_CH2;
            r_rr_ptr    <= 1'b0;
            r_spi_wre   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= c_TMO_ONE;
          r_state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!spi_rdy_i) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmo_cnt >= c_TMO_LAST) begin
            // SPI master never went busy: flag it and treat the frame as sent
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (spi_rdy_i) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_src == SRC_WB && !r_wb_second) begin
            // The second frame follows directly, so channels cannot interleave.
            r_spi_data  <= {CMD_CH2, r_wb_code};
            r_wb_second <= 1'b1;
            r_spi_wre   <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            if (r_src == SRC_WB) begin
              // Pair finished. Promote any write that queued behind it.
              // A write arriving in this very cycle is the newest one.
              r_wb_pend    <= r_wb_requeue | wb_wre_i;
              r_wb_requeue <= 1'b0;
              if (wb_wre_i) begin
                r_wb_code <= wb_code_i;
              end else if (r_wb_requeue) begin
                r_wb_code <= r_wb_next;
              end
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ch1_ack_o  = r_ch1_ack;
  assign ch2_ack_o  = r_ch2_ack;
  assign wb_done_o  = r_wb_done;
  assign wb_pend_o  = r_wb_pend;
  assign spi_data_o = r_spi_data;
  assign spi_wre_o  = r_spi_wre;
  assign busy_o     = (r_state != S_IDLE);
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dac_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_wr_arbiter
//  Purpose  : Directed self-checking bench for dac_wr_arbiter. It includes a
//             behavioural SPI master model and a negedge event monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_wr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        wb_wre   = 1'b0;
  logic [15:0] wb_code  = '0;
  logic        ch1_req  = 1'b0;
  logic [15:0] ch1_code = '0;
  logic        ch2_req  = 1'b0;
  logic [15:0] ch2_code = '0;
  logic        spi_rdy  = 1'b1;
  logic        ch1_ack, ch2_ack, wb_done, wb_pend, spi_wre, busy, err;
  logic [23:0] spi_data;

  int          busy_len   = 10;
  bit          ignore_wre = 1'b0;
  int          cyc        = 0;
  int          errors     = 0;
  int          checks     = 0;

  dac_wr_arbiter #(
    .DATA_WIDTH   (16),
    .CMD_CH1      (8'h18),
    .CMD_CH2      (8'h19),
    .BUSY_TIMEOUT (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_wre_i   (wb_wre),
    .wb_code_i  (wb_code),
    .ch1_req_i  (ch1_req),
    .ch1_code_i (ch1_code),
    .ch2_req_i  (ch2_req),
    .ch2_code_i (ch2_code),
    .ch1_ack_o  (ch1_ack),
    .ch2_ack_o  (ch2_ack),
    .wb_done_o  (wb_done),
    .wb_pend_o  (wb_pend),
    .spi_data_o (spi_data),
    .spi_wre_o  (spi_wre),
    .spi_rdy_i  (spi_rdy),
    .busy_o     (busy),
    .err_o      (err)
  );

  // SPI master model: on a write strobe, ready drops for busy_len cycles
  int mdl_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      spi_rdy <= 1'b1;
      mdl_cnt <= 0;
    end else if (spi_wre && !ignore_wre) begin
      spi_rdy <= 1'b0;
      mdl_cnt <= busy_len;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) spi_rdy <= 1'b1;
    end
  end

  // Event monitor
  logic [23:0] frames [0:63];
  int          nfr = 0, n_ack1 = 0, n_ack2 = 0, n_done = 0;
  int          done_cyc = 0, rise_cyc = 0;
  logic        prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (spi_wre && nfr < 64) begin
      frames[nfr] <= spi_data;
      nfr         <= nfr + 1;
    end
    if (ch1_ack) n_ack1 <= n_ack1 + 1;
    if (ch2_ack) n_ack2 <= n_ack2 + 1;
    if (wb_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (spi_rdy && !prev_rdy) rise_cyc <= cyc;
    prev_rdy <= spi_rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wb(input logic [15:0] code);
    wb_code = code;
    wb_wre  = 1'b1;
    tick();
    wb_wre  = 1'b0;
  endtask

  task automatic wait_wre(input string tag);
    int n = 0;
    while (!spi_wre && n < 100) begin
      tick();
      n++;
    end
    check(tag, {31'd0, spi_wre}, 32'd1);
  endtask

  task automatic wait_quiet(input string tag, input int maxc);
    int n = 0;
    while ((busy || wb_pend) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, {30'd0, busy, wb_pend}, 32'd0);
  endtask

  initial begin
    int base, bd, b1, b2, seen, ordr;

    // ---------------- reset ----------------
    repeat (3) tick();
    check("rst_flags", {25'd0, ch1_ack, ch2_ack, wb_done, wb_pend, spi_wre, busy, err}, 32'd0);
    check("rst_data", {8'd0, spi_data}, 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- Wishbone pair ----------------
    busy_len = 10;
    base = nfr; bd = n_done; b1 = n_ack1; b2 = n_ack2;
    pulse_wb(16'h1234);
    check("s1_pend_set", {31'd0, wb_pend}, 32'd1);
    wait_quiet("s1_quiet", 200);
    check("s1_nframes", nfr - base, 32'd2);
    check("s1_frame0", {8'd0, frames[base]}, 32'h181234);
    check("s1_frame1", {8'd0, frames[base+1]}, 32'h191234);
    check("s1_done_cnt", n_done - bd, 32'd1);
    check("s1_done_lat", done_cyc - rise_cyc, 32'd1);
    check("s1_no_acks", (n_ack1 - b1) + (n_ack2 - b2), 32'd0);

    // ---------------- round robin ----------------
    busy_len = 3;
    ch1_code = 16'h0100; ch2_code = 16'h0200;
    base = nfr; seen = 0; ordr = 0;
    ch1_req = 1'b1; ch2_req = 1'b1;
    for (int n = 0; n < 400 && seen < 4; n++) begin
      tick();
      if (ch1_ack) begin seen++; ordr = ordr * 4 + 1; end
      if (ch2_ack) begin seen++; ordr = ordr * 4 + 2; end
    end
    ch1_req = 1'b0; ch2_req = 1'b0;
    check("s2_ack_count", seen, 32'd4);
    check("s2_ack_order", ordr, 32'd102);  // 1,2,1,2 in base 4
    check("s2_frame0", {8'd0, frames[base]},   32'h180100);
    check("s2_frame1", {8'd0, frames[base+1]}, 32'h190200);
    check("s2_frame2", {8'd0, frames[base+2]}, 32'h180100);
    check("s2_frame3", {8'd0, frames[base+3]}, 32'h190200);
    wait_quiet("s2_quiet", 100);

    // ---------------- Wishbone arrives during ch1 WAIT_DONE ----------------
    busy_len = 6;
    ch1_code = 16'h0011;
    base = nfr; bd = n_done; seen = 0;
    ch1_req = 1'b1;
    wait_wre("s3_wre");
    repeat (3) tick();
    check("s3_in_frame", {31'd0, busy}, 32'd1);
    pulse_wb(16'h5555);
    for (int n = 0; n < 400 && seen < 2; n++) begin
      tick();
      if (ch1_ack) seen++;
    end
    ch1_req = 1'b0;
    wait_quiet("s3_quiet", 100);
    check("s3_acks", seen, 32'd2);
    check("s3_nframes", nfr - base, 32'd4);
    check("s3_frame0", {8'd0, frames[base]},   32'h180011);
    check("s3_frame1", {8'd0, frames[base+1]}, 32'h185555);
    check("s3_frame2", {8'd0, frames[base+2]}, 32'h195555);
    check("s3_frame3", {8'd0, frames[base+3]}, 32'h180011);
    check("s3_done_cnt", n_done - bd, 32'd1);

    // ---------------- two Wishbone writes while ch2 is mid-frame ----------------
    ch2_code = 16'h0222;
    base = nfr; bd = n_done; b2 = n_ack2; seen = 0;
    ch2_req = 1'b1;
    wait_wre("s4_wre");
    repeat (2) tick();
    pulse_wb(16'hAAAA);
    pulse_wb(16'hBBBB);
    for (int n = 0; n < 400 && seen < 1; n++) begin
      tick();
      if (ch2_ack) seen++;
    end
    ch2_req = 1'b0;
    wait_quiet("s4_quiet", 100);
    check("s4_nframes", nfr - base, 32'd3);
    check("s4_frame0", {8'd0, frames[base]},   32'h190222);
    check("s4_frame1", {8'd0, frames[base+1]}, 32'h18BBBB);
    check("s4_frame2", {8'd0, frames[base+2]}, 32'h19BBBB);
    check("s4_done_cnt", n_done - bd, 32'd1);
    check("s4_ack2_cnt", n_ack2 - b2, 32'd1);

    // ---------------- SPI master ignores the strobe ----------------
    ignore_wre = 1'b1;
    ch1_code = 16'h0033;
    base = nfr;
    ch1_req = 1'b1;
    wait_wre("s5_wre");
    repeat (3) tick();
    check("s5_err_early", {31'd0, err}, 32'd0);
    tick();
    check("s5_err_set", {31'd0, err}, 32'd1);
    check("s5_ack", {31'd0, ch1_ack}, 32'd1);
    ch1_req = 1'b0;
    wait_quiet("s5_quiet", 100);
    ignore_wre = 1'b0;
    repeat (5) tick();
    check("s5_err_sticky", {31'd0, err}, 32'd1);
    check("s5_frame", {8'd0, frames[base]}, 32'h180033);

    // ---------------- reset during WAIT_DONE ----------------
    busy_len = 8;
    ch2_code = 16'h0444;
    ch2_req = 1'b1;
    wait_wre("s6_wre");
    repeat (3) tick();
    check("s6_busy_pre", {31'd0, busy}, 32'd1);
    b2 = n_ack2;
    rst = 1'b1;
    tick();
    check("s6_rst_flags", {25'd0, ch1_ack, ch2_ack, wb_done, wb_pend, spi_wre, busy, err}, 32'd0);
    check("s6_rst_data", {8'd0, spi_data}, 32'd0);
    rst = 1'b0;
    ch2_req = 1'b0;
    repeat (15) tick();
    check("s6_no_ack", n_ack2 - b2, 32'd0);
    check("s6_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
